// File: rtl/module_muldiv_ctrl.sv
// module_muldiv_ctrl: iterative RV32M multiply/divide unit for the Execute stage.
// Runs one radix-2 shift-add or restoring-divide step per cycle on operand
// magnitudes, then applies the result sign at the end.
// Optional macro MULDIV_FAST_EN: divide-by-zero, signed overflow and multiply
// by zero skip the iterations and complete one cycle after acceptance.
module module_muldiv_ctrl #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            start_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] srca_i,
    input  logic [XLEN-1:0] srcb_i,
    input  logic [4:0]      rde_i,
    input  logic            flushe_i,
    output logic            stall_o,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o,
    output logic [4:0]      rd_o
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t            state, state_nx;
    logic [4:0]        cnt;
    logic [XLEN-1:0]   mag_b;
    logic [2*XLEN-1:0] acc, acc_nx;
    logic [2:0]        op_q;
    logic [4:0]        rd_q;
    logic              neg_res, neg_a_q, divz_q;

    logic              start_ok, is_div, sgn_a, sgn_b, in_neg_a, in_neg_b;
    logic [XLEN-1:0]   in_mag_a, in_mag_b;
    logic              fast;
    logic [XLEN-1:0]   fast_res;
    logic [XLEN:0]     trial, sum;
    logic              ge;
    logic [XLEN-1:0]   new_rem;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo, rem, calc_res;

    // Decode the incoming op: which operands are signed, and their magnitudes.
    always_comb begin
        start_ok = start_i & ~flushe_i;
        is_div   = funct3_i[2];
        sgn_a    = is_div ? ~funct3_i[0] : (funct3_i != 3'b011);
        sgn_b    = is_div ? ~funct3_i[0] : ~funct3_i[1];
        in_neg_a = sgn_a & srca_i[XLEN-1];
        in_neg_b = sgn_b & srcb_i[XLEN-1];
        in_mag_a = in_neg_a ? (~srca_i + 1'b1) : srca_i;
        in_mag_b = in_neg_b ? (~srcb_i + 1'b1) : srcb_i;
    end

`ifdef MULDIV_FAST_EN
    // Spot the trivial cases whose answer is known without iterating.
    always_comb begin
        fast     = 1'b0;
        fast_res = '0;
        if (is_div) begin
            if (srcb_i == '0) begin
                fast     = 1'b1;
                fast_res = funct3_i[1] ? srca_i : '1;
            end else if (~funct3_i[0] && srca_i == {1'b1, {(XLEN-1){1'b0}}} && srcb_i == '1) begin
                fast     = 1'b1;
                fast_res = funct3_i[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
            end
        end else if (srca_i == '0 || srcb_i == '0) begin
            fast     = 1'b1;
            fast_res = '0;
        end
    end
`else
    // Every op takes the full iterative path in this build.
    always_comb begin
        fast     = 1'b0;
        fast_res = '0;
    end
`endif

    // One iteration step plus sign correction of the would-be final result.
    always_comb begin
        trial    = acc[2*XLEN-1:XLEN-1];
        ge       = trial[XLEN] | (trial[XLEN-1:0] >= mag_b);
        new_rem  = trial[XLEN-1:0] - (ge ? mag_b : '0);
        sum      = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mag_b} : '0);
        if (op_q[2]) begin
            acc_nx = {new_rem, acc[XLEN-2:0], ge};
        end else begin
            acc_nx = {sum, acc[XLEN-1:1]};
        end
        prod = neg_res ? (~acc_nx + 1'b1) : acc_nx;
        quo  = divz_q ? '1 : (neg_res ? (~acc_nx[XLEN-1:0] + 1'b1) : acc_nx[XLEN-1:0]);
        rem  = neg_a_q ? (~acc_nx[2*XLEN-1:XLEN] + 1'b1) : acc_nx[2*XLEN-1:XLEN];
        case (op_q)
            3'b000:                 calc_res = prod[XLEN-1:0];
            3'b001, 3'b010, 3'b011: calc_res = prod[2*XLEN-1:XLEN];
            3'b100, 3'b101:         calc_res = quo;
            default:                calc_res = rem;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state <= IDLE;
        else          state <= state_nx;
    end

    // Next-state logic and handshake outputs.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (start_ok) state_nx = fast ? DONE : CALC;
            CALC: begin
                if (flushe_i)          state_nx = IDLE;
                else if (cnt == 5'd31) state_nx = DONE;
            end
            default: state_nx = IDLE;
        endcase
        stall_o = rst_n_i & (((state == IDLE) & start_ok) | (state == CALC));
        busy_o  = (state != IDLE);
        done_o  = (state == DONE) & ~flushe_i;
    end

    // Operand capture, iteration datapath and result/destination registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt      <= '0;
            mag_b    <= '0;
            acc      <= '0;
            op_q     <= '0;
            rd_q     <= '0;
            neg_res  <= 1'b0;
            neg_a_q  <= 1'b0;
            divz_q   <= 1'b0;
            result_o <= '0;
            rd_o     <= '0;
        end else if (state == IDLE && start_ok) begin
            cnt     <= '0;
            mag_b   <= in_mag_b;
            acc     <= {{XLEN{1'b0}}, in_mag_a};
            op_q    <= funct3_i;
            rd_q    <= rde_i;
            neg_res <= in_neg_a ^ in_neg_b;
            neg_a_q <= in_neg_a;
            divz_q  <= (srcb_i == '0);
            if (fast) begin
                result_o <= fast_res;
                rd_o     <= rde_i;
            end
        end else if (state == CALC && !flushe_i) begin
            acc <= acc_nx;
            cnt <= cnt + 5'd1;
            if (cnt == 5'd31) begin
                result_o <= calc_res;
                rd_o     <= rd_q;
            end
        end
    end

endmodule

// File: doc/module_muldiv_ctrl.md
MODULE_MULDIV_CTRL -- requirements
Module: module_muldiv_ctrl

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, giving operand/result width; only 32 is supported.
REQ-002 The block SHALL have port clk_i, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n_i, input, 1, reset; asynchronous, active-low.
REQ-004 The block SHALL have port start_i, input, 1, valid M-extension op in Execute.
REQ-005 The block SHALL have port funct3_i, input, 3, op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 The block SHALL have ports srca_i and srcb_i, input, XLEN each, forwarded operands rs1 and rs2.
REQ-007 The block SHALL have port rde_i, input, 5, destination register of the Execute instruction.
REQ-008 The block SHALL have port flushe_i, input, 1, Execute flush from the hazard unit.
REQ-009 The block SHALL have port stall_o, output, 1, hold request for Fetch, Decode and Execute registers.
REQ-010 The block SHALL have ports busy_o, output, 1 (state is not IDLE), and done_o, output, 1 (one-cycle result strobe).
REQ-011 The block SHALL have ports result_o, output, XLEN, and rd_o, output, 5, the result and the latched destination.

Function
REQ-012 The FSM SHALL have three states: IDLE, CALC and DONE.
REQ-013 In IDLE, start_i=1 with flushe_i=0 SHALL latch operands, funct3 and rde_i, clear the iteration counter and go to CALC.
REQ-014 stall_o SHALL be combinational: (IDLE & start_i & !flushe_i) | CALC; it is never asserted in DONE.
REQ-015 CALC SHALL perform one radix-2 iteration per cycle for exactly 32 cycles (counter 0..31), then go to DONE.
REQ-016 Multiply SHALL be shift-add on operand magnitudes, producing a 64-bit product; MUL returns the low word, MULH/MULHSU/MULHU the high word.
REQ-017 Divide SHALL be restoring division on magnitudes; the quotient sign is signA^signB and the remainder takes the dividend's sign.
REQ-018 Signedness: MULH, DIV and REM are signed/signed; MULHSU is signed rs1 with unsigned rs2; MULHU, DIVU and REMU are unsigned.
REQ-019 Division by zero SHALL give quotient 0xFFFFFFFF and remainder equal to the dividend.
REQ-020 Signed overflow, 0x80000000 / 0xFFFFFFFF, SHALL give quotient 0x80000000 and remainder 0.
REQ-021 In DONE, done_o=1 and result_o/rd_o SHALL be valid for exactly one cycle; the next state is unconditionally IDLE.
REQ-022 start_i seen in DONE SHALL be ignored, since it is the same instruction leaving Execute.
REQ-023 Latency: accept at cycle 0, CALC cycles 1..32, done_o at cycle 33; stall_o is high on cycles 0..32.
REQ-024 flushe_i=1 in CALC SHALL abort to IDLE at the next edge with no done_o.
REQ-025 flushe_i=1 in DONE SHALL suppress done_o in that cycle.
REQ-026 result_o and rd_o SHALL hold their last value outside DONE; consumers use done_o only.

Reset
REQ-027 When rst_n_i is low, the state SHALL be IDLE and the counter, operand registers, result_o, rd_o, done_o and busy_o SHALL be 0, immediately and without a clock.
REQ-028 stall_o SHALL be 0 during reset regardless of start_i.
REQ-029 Reset asserted mid-CALC SHALL discard the operation; after release the block accepts a new start_i the same cycle.

Configuration
REQ-030 Macro MULDIV_FAST_EN SHALL, when defined, make the following cases go IDLE->DONE directly, with a one-cycle stall and done_o at cycle 1:
- divide by zero;
- signed overflow;
- multiply with either operand zero.
REQ-031 Without MULDIV_FAST_EN, every op SHALL take the full 32 CALC cycles; results SHALL be identical in both builds.

Verification
REQ-032 MUL 7 x 0xFFFFFFFA (-6) -> done_o at cycle 33, result_o=0xFFFFFFD6, stall_o high cycles 0..32.
REQ-033 MULHU 0xFFFFFFFF x 0xFFFFFFFF -> result_o=0xFFFFFFFE; MULHSU 0xFFFFFFFF x 2 -> result_o=0xFFFFFFFF.
REQ-034 DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/0 -> 0xFFFFFFFF; REM 0x80000000/-1 -> 0.
REQ-035 DIV 5/0 -> 0xFFFFFFFF, with done_o at cycle 1 if MULDIV_FAST_EN is defined, else at cycle 33.
REQ-036 DIVU with flushe_i pulsed at cycle 10 -> IDLE at cycle 11, no done_o, stall_o=0; a new start_i at cycle 12 completes normally.
REQ-037 rst_n_i low at cycle 15 of a MUL -> outputs zero immediately; start_i held through DONE -> exactly one done_o.
